// File: rtl/core_types_pkg.sv
// Shared core parameters and PRF write-path types.
// Imported by the PRF write scheduler and its arbiter.
package core_types_pkg;

  localparam int PRF_WR_COUNT             = 8;
  localparam int PRF_BANK_COUNT           = 4;
  localparam int LOG_PRF_BANK_COUNT       = 2;
  localparam int PR_COUNT                 = 128;
  localparam int LOG_PR_COUNT             = 7;
  localparam int PRF_WR_INPUT_BUFFER_SIZE = 2;
  localparam int XLEN                     = 32;
  localparam int LOG_PRF_WR_COUNT         = $clog2(PRF_WR_COUNT);

  localparam int UPPER_PR_W   = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  localparam int LOG_BUF_SIZE = (PRF_WR_INPUT_BUFFER_SIZE > 1) ? $clog2(PRF_WR_INPUT_BUFFER_SIZE) : 1;
  localparam int BUF_CNT_W    = $clog2(PRF_WR_INPUT_BUFFER_SIZE + 1);

  typedef struct packed {
    logic [LOG_PR_COUNT-1:0] pr;
    logic [XLEN-1:0]         data;
  } prf_wr_entry_t;

  // Pointer increment that wraps modulo the buffer depth (depth need not be a power of two).
  function automatic logic [LOG_BUF_SIZE-1:0] buf_ptr_next(input logic [LOG_BUF_SIZE-1:0] ptr);
    if (int'(ptr) == PRF_WR_INPUT_BUFFER_SIZE - 1) return '0;
    return ptr + LOG_BUF_SIZE'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above i_rr wins, searching upward
// with wraparound. Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter  int REQ_COUNT = 8,
  localparam int IDX_W     = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic [REQ_COUNT-1:0] i_req,
  input  logic [IDX_W-1:0]     i_rr,
  output logic                 o_gnt_valid,
  output logic [IDX_W-1:0]     o_gnt_idx
);

  int w_idx;

  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_idx       = 0;
    // Walk from farthest to nearest so the last hit is the one closest to the pointer.
    for (int k = REQ_COUNT - 1; k >= 0; k--) begin
      w_idx = int'(i_rr) + k;
      if (w_idx >= REQ_COUNT) w_idx = w_idx - REQ_COUNT;
      if (i_req[w_idx[IDX_W-1:0]]) begin
        o_gnt_valid = 1'b1;
        o_gnt_idx   = IDX_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/prf_wr_scheduler.sv
// Buffers writeback requests per source and steers FIFO heads onto single-port PRF banks,
// one round-robin arbiter per bank. Bank outputs are combinational from registered state.
module prf_wr_scheduler
  import core_types_pkg::*;
(
  input  logic                                              CLK,
  input  logic                                              nRST,
  input  logic [PRF_WR_COUNT-1:0]                           WB_valid_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]         WB_PR_by_wr,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]                 WB_data_by_wr,
  output logic [PRF_WR_COUNT-1:0]                           WB_ready_by_wr,
  output logic [PRF_BANK_COUNT-1:0]                         prf_wr_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]         prf_wr_upper_PR_by_bank,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]               prf_wr_data_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PRF_WR_COUNT-1:0]   prf_wr_src_by_bank
);

  prf_wr_entry_t               r_fifo  [PRF_WR_COUNT][PRF_WR_INPUT_BUFFER_SIZE];
  logic [LOG_BUF_SIZE-1:0]     r_head  [PRF_WR_COUNT];
  logic [LOG_BUF_SIZE-1:0]     r_tail  [PRF_WR_COUNT];
  logic [BUF_CNT_W-1:0]        r_count [PRF_WR_COUNT];
  logic [LOG_PRF_WR_COUNT-1:0] r_rr    [PRF_BANK_COUNT];

  prf_wr_entry_t                                  w_head [PRF_WR_COUNT];
  logic [PRF_WR_COUNT-1:0]                        w_enq;
  logic [PRF_WR_COUNT-1:0]                        w_deq;
  logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]    w_req;
  logic [PRF_BANK_COUNT-1:0]                      w_gnt_valid;
  logic [LOG_PRF_WR_COUNT-1:0]                    w_gnt_idx [PRF_BANK_COUNT];

  // Ready looks only at the registered count, so grants never feed back into it.
  always_comb begin
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      w_head[i]         = r_fifo[i][r_head[i]];
      WB_ready_by_wr[i] = (r_count[i] != BUF_CNT_W'(PRF_WR_INPUT_BUFFER_SIZE));
      w_enq[i]          = WB_valid_by_wr[i] & WB_ready_by_wr[i];
    end
  end

  always_comb begin
    w_req = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        w_req[b][i] = (r_count[i] != '0) &&
                      (w_head[i].pr[LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
      end
    end
  end

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank_arb
    rr_arbiter #(.REQ_COUNT(PRF_WR_COUNT)) u_rr_arbiter (
      .i_req       (w_req[b]),
      .i_rr        (r_rr[b]),
      .o_gnt_valid (w_gnt_valid[b]),
      .o_gnt_idx   (w_gnt_idx[b])
    );
  end

  // A head targets one bank only, so at most one bank can grant any given source.
  always_comb begin
    w_deq = '0;
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (w_gnt_valid[b] && (w_gnt_idx[b] == LOG_PRF_WR_COUNT'(i))) w_deq[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nRST) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        r_head[i]  <= '0;
        r_tail[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (w_enq[i]) r_tail[i] <= buf_ptr_next(r_tail[i]);
        if (w_deq[i]) r_head[i] <= buf_ptr_next(r_head[i]);
        case ({w_enq[i], w_deq[i]})
          2'b10:   r_count[i] <= r_count[i] + BUF_CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - BUF_CNT_W'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // NOTE: the entry storage has no reset; validity is tracked entirely by the counts and pointers.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      if (w_enq[i]) r_fifo[i][r_tail[i]] <= '{pr: WB_PR_by_wr[i], data: WB_data_by_wr[i]};
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) r_rr[b] <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (w_gnt_valid[b]) begin
          r_rr[b] <= (int'(w_gnt_idx[b]) == PRF_WR_COUNT - 1) ? '0
                                                               : w_gnt_idx[b] + LOG_PRF_WR_COUNT'(1);
        end
      end
    end
  end

  always_comb begin
    prf_wr_valid_by_bank    = '0;
    prf_wr_upper_PR_by_bank = '0;
    prf_wr_data_by_bank     = '0;
    prf_wr_src_by_bank      = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      if (w_gnt_valid[b]) begin
        prf_wr_valid_by_bank[b]    = 1'b1;
        prf_wr_upper_PR_by_bank[b] = w_head[w_gnt_idx[b]].pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
        prf_wr_data_by_bank[b]     = w_head[w_gnt_idx[b]].data;
        prf_wr_src_by_bank[b]      = w_gnt_idx[b];
      end
    end
  end

endmodule

// File: tb/tb_prf_wr_scheduler.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's bank writes and
// ready vector; a monitor pops the predictions and compares them against the DUT.
module tb_prf_wr_scheduler;
  import core_types_pkg::*;

  logic                                            CLK = 1'b0;
  logic                                            nRST;
  logic [PRF_WR_COUNT-1:0]                         WB_valid_by_wr;
  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]       WB_PR_by_wr;
  logic [PRF_WR_COUNT-1:0][XLEN-1:0]               WB_data_by_wr;
  logic [PRF_WR_COUNT-1:0]                         WB_ready_by_wr;
  logic [PRF_BANK_COUNT-1:0]                       prf_wr_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]       prf_wr_upper_PR_by_bank;
  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]             prf_wr_data_by_bank;
  logic [PRF_BANK_COUNT-1:0][LOG_PRF_WR_COUNT-1:0] prf_wr_src_by_bank;

  always #5 CLK = ~CLK;

  prf_wr_scheduler dut (
    .CLK                     (CLK),
    .nRST                    (nRST),
    .WB_valid_by_wr          (WB_valid_by_wr),
    .WB_PR_by_wr             (WB_PR_by_wr),
    .WB_data_by_wr           (WB_data_by_wr),
    .WB_ready_by_wr          (WB_ready_by_wr),
    .prf_wr_valid_by_bank    (prf_wr_valid_by_bank),
    .prf_wr_upper_PR_by_bank (prf_wr_upper_PR_by_bank),
    .prf_wr_data_by_bank     (prf_wr_data_by_bank),
    .prf_wr_src_by_bank      (prf_wr_src_by_bank)
  );

  typedef struct packed {
    logic [LOG_PR_COUNT-1:0] pr;
    logic [XLEN-1:0]         data;
  } ent_t;

  typedef struct packed {
    logic [PRF_WR_COUNT-1:0]                         ready;
    logic [PRF_BANK_COUNT-1:0]                       valid;
    logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]       upper;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]             data;
    logic [PRF_BANK_COUNT-1:0][LOG_PRF_WR_COUNT-1:0] src;
  } exp_t;

  ent_t mq [PRF_WR_COUNT][$];  // model of each source buffer
  ent_t sq [PRF_WR_COUNT][$];  // pending stimulus per source, head is driven
  int   mrr [PRF_BANK_COUNT];
  exp_t exp_q [$];
  bit   model_known = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy();
    for (int i = 0; i < PRF_WR_COUNT; i++) if (sq[i].size() > 0 || mq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void req(input int src, input int pr, input logic [XLEN-1:0] data);
    ent_t e;
    e.pr   = LOG_PR_COUNT'(pr);
    e.data = data;
    sq[src].push_back(e);
  endfunction

  function automatic void add_random(input int hot_bank, input int prob_pct);
    int pr;
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      if (sq[i].size() == 0 && $urandom_range(99) < prob_pct) begin
        pr = $urandom_range(PR_COUNT - 1);
        if (hot_bank >= 0 && $urandom_range(1) == 1) pr = pr - (pr % PRF_BANK_COUNT) + hot_bank;
        req(i, pr, $urandom);
      end
    end
  endfunction

  // One clock cycle: drive pending heads, predict this cycle's outputs, advance the model.
  task automatic tick();
    logic [PRF_WR_COUNT-1:0] rdy;
    int   win [PRF_BANK_COUNT];
    int   s;
    exp_t e;
    for (int i = 0; i < PRF_WR_COUNT; i++) begin
      if (sq[i].size() > 0) begin
        WB_valid_by_wr[i] = 1'b1;
        WB_PR_by_wr[i]    = sq[i][0].pr;
        WB_data_by_wr[i]  = sq[i][0].data;
      end else begin
        WB_valid_by_wr[i] = 1'b0;
        WB_PR_by_wr[i]    = '0;
        WB_data_by_wr[i]  = '0;
      end
      rdy[i] = (mq[i].size() < PRF_WR_INPUT_BUFFER_SIZE);
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      win[b] = -1;
      for (int k = 0; k < PRF_WR_COUNT; k++) begin
        s = (mrr[b] + k) % PRF_WR_COUNT;
        if (win[b] < 0 && mq[s].size() > 0 && int'(mq[s][0].pr) % PRF_BANK_COUNT == b) win[b] = s;
      end
    end
    if (model_known) begin
      e = '0;
      e.ready = rdy;
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (win[b] >= 0) begin
          e.valid[b] = 1'b1;
          e.upper[b] = UPPER_PR_W'(int'(mq[win[b]][0].pr) / PRF_BANK_COUNT);
          e.data[b]  = mq[win[b]][0].data;
          e.src[b]   = LOG_PRF_WR_COUNT'(win[b]);
        end
      end
      exp_q.push_back(e);
    end
    if (!nRST) begin
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        mq[i].delete();
        sq[i].delete();
      end
      for (int b = 0; b < PRF_BANK_COUNT; b++) mrr[b] = 0;
      model_known = 1'b1;
    end else if (model_known) begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (win[b] >= 0) begin
          void'(mq[win[b]].pop_front());
          mrr[b] = (win[b] + 1) % PRF_WR_COUNT;
        end
      end
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        if (WB_valid_by_wr[i] && rdy[i]) mq[i].push_back(sq[i].pop_front());
      end
    end
    @(negedge CLK);
  endtask

  task automatic drain();
    int n = 0;
    while (busy() && n < 200) begin
      tick();
      n++;
    end
    check("drain_complete", 64'(busy()), 64'(0));
  endtask

  // Monitor: samples mid-low-phase, after the stimulus has pushed this cycle's prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ready", 64'(WB_ready_by_wr), 64'(e.ready));
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
          check($sformatf("bank%0d_valid", b), 64'(prf_wr_valid_by_bank[b]),    64'(e.valid[b]));
          check($sformatf("bank%0d_upper", b), 64'(prf_wr_upper_PR_by_bank[b]), 64'(e.upper[b]));
          check($sformatf("bank%0d_data", b),  64'(prf_wr_data_by_bank[b]),     64'(e.data[b]));
          check($sformatf("bank%0d_src", b),   64'(prf_wr_src_by_bank[b]),      64'(e.src[b]));
        end
      end
    end
  end

  initial begin
    nRST           = 1'b0;
    WB_valid_by_wr = '0;
    WB_PR_by_wr    = '0;
    WB_data_by_wr  = '0;
    @(negedge CLK);
    tick();
    tick();
    nRST = 1'b1;
    #1;
    check("reset_ready_all", 64'(WB_ready_by_wr), 64'({PRF_WR_COUNT{1'b1}}));
    check("reset_valid_none", 64'(prf_wr_valid_by_bank), 64'(0));
    check("reset_src_zero", 64'(prf_wr_src_by_bank), 64'(0));

    // Single write: PR 0x2D lands in bank 1, row 0x0B, one cycle after acceptance.
    req(3, 'h2D, 32'hDEADBEEF);
    tick();
    #1;
    check("single_valid_vec", 64'(prf_wr_valid_by_bank), 64'(4'b0010));
    check("single_upper", 64'(prf_wr_upper_PR_by_bank[1]), 64'('h0B));
    check("single_data", 64'(prf_wr_data_by_bank[1]), 64'(32'hDEADBEEF));
    check("single_src", 64'(prf_wr_src_by_bank[1]), 64'(3));
    drain();

    // Full contention on bank 2: grants in source order, one per cycle.
    for (int i = 0; i < PRF_WR_COUNT; i++) req(i, ($urandom_range(31) * 4) + 2, $urandom);
    tick();
    for (int k = 0; k < PRF_WR_COUNT; k++) begin
      #1;
      check("contention_valid", 64'(prf_wr_valid_by_bank[2]), 64'(1));
      check("contention_src", 64'(prf_wr_src_by_bank[2]), 64'(k));
      tick();
    end
    drain();
    // Pointer must have wrapped to 0: source 0 beats source 7.
    req(7, 'h06, 32'h7777_0007);
    req(0, 'h0A, 32'h0000_000A);
    tick();
    #1;
    check("rr_wrap_src", 64'(prf_wr_src_by_bank[2]), 64'(0));
    drain();

    // Disjoint banks: all four write together.
    for (int b = 0; b < PRF_BANK_COUNT; b++) req(b, ($urandom_range(31) * 4) + b, $urandom);
    tick();
    #1;
    check("disjoint_valid_vec", 64'(prf_wr_valid_by_bank), 64'(4'b1111));
    for (int b = 0; b < PRF_BANK_COUNT; b++) check($sformatf("disjoint_src%0d", b), 64'(prf_wr_src_by_bank[b]), 64'(b));
    drain();

    // Backpressure: source 5 queues three bank-0 writes behind sources 0..4.
    for (int i = 0; i < 5; i++) req(i, ($urandom_range(31) * 4), $urandom);
    for (int j = 0; j < 3; j++) req(5, ($urandom_range(31) * 4), 32'h5500_0000 + j);
    tick();
    tick();
    #1;
    check("bp_ready5_low", 64'(WB_ready_by_wr[5]), 64'(0));
    drain();

    repeat (300) begin
      add_random(($urandom_range(3) == 0) ? int'($urandom_range(PRF_BANK_COUNT - 1)) : -1, 40);
      tick();
    end

    // Reset while buffers are partly full.
    repeat (6) begin
      add_random(-1, 80);
      tick();
    end
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #1;
    check("midreset_ready_all", 64'(WB_ready_by_wr), 64'({PRF_WR_COUNT{1'b1}}));
    check("midreset_valid_none", 64'(prf_wr_valid_by_bank), 64'(0));
    repeat (4) tick();

    repeat (200) begin
      add_random(($urandom_range(1) == 0) ? int'($urandom_range(PRF_BANK_COUNT - 1)) : -1, 60);
      tick();
    end
    drain();
    repeat (2) @(negedge CLK);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
